// File: rtl/tc_pkg.sv
// Shared tensor-core types: fflags layout and the ctrl sideband carried alongside each product beat.
package tc_pkg;

   localparam int FFLAGS_W   = 5;
   localparam int FFLAG_NV   = 4;
   localparam int FFLAG_DZ   = 3;
   localparam int FFLAG_OF   = 2;
   localparam int FFLAG_UF   = 1;
   localparam int FFLAG_NX   = 0;

   // Mirrors of the default top-level widths; the struct layout must match them
   localparam int TC_CTRL_C_W   = 16;
   localparam int TC_RM_W       = 3;
   localparam int TC_REG_IDX_W  = 8;
   localparam int TC_WARP_W     = 4;

   typedef struct packed {
      logic [TC_CTRL_C_W-1:0]  ctrl_c;
      logic [TC_RM_W-1:0]      rm;
      logic [TC_REG_IDX_W-1:0] reg_idxw;
      logic [TC_WARP_W-1:0]    warpid;
   } tc_ctrl_t;

endpackage

// File: rtl/tc_sync_fifo.sv
// Generic single-clock FIFO with occupancy count; storage is deliberately not reset.
module tc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_rd)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)
            count <= count + CW'(1);
         else if (do_rd && !do_wr)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/tc_mul_wb_buffer.sv
// Buffers tensor-core multiply results for register writeback and keeps sticky per-warp fflags.
module tc_mul_wb_buffer
   import tc_pkg::*;
#(
   parameter int SHAPE_K       = 8,
   parameter int ELEMENT_WIDTH = 9,
   parameter int CTRL_C_WIDTH  = 16,
   parameter int DEPTH_WARP    = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid_i,
   output logic                                  in_ready_o,
   input  logic [SHAPE_K*ELEMENT_WIDTH-1:0]      result_i,
   input  logic [FFLAGS_W-1:0]                   fflags_i,
   input  logic [CTRL_C_WIDTH-1:0]               ctrl_c_i,
   input  logic [2:0]                            ctrl_rm_i,
   input  logic [7:0]                            ctrl_reg_idxw_i,
   input  logic [DEPTH_WARP-1:0]                 ctrl_warpid_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [SHAPE_K*ELEMENT_WIDTH-1:0]      wb_data_o,
   output logic [FFLAGS_W-1:0]                   wb_fflags_o,
   output logic [CTRL_C_WIDTH-1:0]               wb_ctrl_c_o,
   output logic [2:0]                            wb_rm_o,
   output logic [7:0]                            wb_reg_idxw_o,
   output logic [DEPTH_WARP-1:0]                 wb_warpid_o,
   input  logic                                  fflags_clr_i,
   input  logic [DEPTH_WARP-1:0]                 fflags_clr_warp_i,
   output logic [FFLAGS_W*(2**DEPTH_WARP)-1:0]   fflags_acc_o,
   output logic [$clog2(FIFO_DEPTH):0]           count_o
);

   localparam int DATA_W    = SHAPE_K * ELEMENT_WIDTH;
   localparam int WORD_W    = DATA_W + FFLAGS_W + $bits(tc_ctrl_t);
   localparam int NUM_WARPS = 2 ** DEPTH_WARP;

   tc_ctrl_t          ctrl_in;
   tc_ctrl_t          ctrl_out;
   logic [WORD_W-1:0] fifo_in;
   logic [WORD_W-1:0] fifo_out;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [FFLAGS_W-1:0] acc [NUM_WARPS];

   assign in_ready_o  = !rst && !fifo_full;
   assign out_valid_o = !fifo_empty;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   assign ctrl_in.ctrl_c   = ctrl_c_i;
   assign ctrl_in.rm       = ctrl_rm_i;
   assign ctrl_in.reg_idxw = ctrl_reg_idxw_i;
   assign ctrl_in.warpid   = ctrl_warpid_i;
   assign fifo_in          = {result_i, fflags_i, ctrl_in};

   assign {wb_data_o, wb_fflags_o, ctrl_out} = fifo_out;
   assign wb_ctrl_c_o   = ctrl_out.ctrl_c;
   assign wb_rm_o       = ctrl_out.rm;
   assign wb_reg_idxw_o = ctrl_out.reg_idxw;
   assign wb_warpid_o   = ctrl_out.warpid;

   tc_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (fifo_in),
      .rd_en   (pop),
      .rd_data (fifo_out),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count_o)
   );

   // Clear is applied before the OR so a same-cycle push to the cleared warp survives
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NUM_WARPS; w++)
            acc[w] <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (fflags_clr_i && (fflags_clr_warp_i == DEPTH_WARP'(w)))
               acc[w] <= (push && (ctrl_warpid_i == DEPTH_WARP'(w))) ? fflags_i : '0;
            else if (push && (ctrl_warpid_i == DEPTH_WARP'(w)))
               acc[w] <= acc[w] | fflags_i;
         end
      end
   end

   always_comb begin
      fflags_acc_o = '0;
      for (int w = 0; w < NUM_WARPS; w++)
         fflags_acc_o[w*FFLAGS_W +: FFLAGS_W] = acc[w];
   end

endmodule
